// File: rtl/timer_dev.sv
// timer_dev: programmable interval timer with one-shot/periodic countdown and a maskable interrupt
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t state, next;
  logic en, im, pending;
  logic [1:0] mode;
  logic [CNT_W-1:0] preset, count;
  logic wr_ctrl, wr_pre, periodic, terminal;
  assign wr_ctrl = sel & we & (addr == 2'd0);
  assign wr_pre = sel & we & (addr == 2'd1);
  assign periodic = mode == 2'b01;
  assign terminal = state == CNT && en && count <= CNT_W'(1);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = en ? LOAD : IDLE;
      LOAD: next = CNT;
      CNT:  next = !en ? IDLE : (count <= CNT_W'(1) ? INT : CNT);
      INT:  next = periodic ? LOAD : IDLE;
      default: next = IDLE;
    endcase
  end
  // a CPU write to CTRL overrides the automatic EN clear; a pending set overrides the write's acknowledge
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      en <= 1'b0;
      mode <= 2'b00;
      im <= 1'b0;
      preset <= '0;
      count <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_ctrl) {im, mode, en} <= din[3:0];
      else if (terminal && !periodic) en <= 1'b0;
      if (wr_pre) preset <= din[CNT_W-1:0];
      if (state == LOAD) count <= preset;
      else if (state == CNT && en) count <= count > CNT_W'(1) ? count - CNT_W'(1) : '0;
      if (terminal) pending <= 1'b1;
      else if ((state == INT && periodic) || wr_ctrl || wr_pre) pending <= 1'b0;
    end
  always_comb begin
    irq = pending & im;
    dout = addr == 2'd0 ? {28'd0, im, mode, en} :
           addr == 2'd1 ? 32'(preset) :
           addr == 2'd2 ? 32'(count) : 32'd0;
  end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed/randomized checks of timer_dev against an arithmetic timing model
module tb_timer_dev;
  logic clock = 1'b0;
  logic reset, sel, we, irq;
  logic [1:0] addr;
  logic [31:0] din, dout, rv;
  int n_cmp = 0, n_err = 0;
  int ps[4];
  logic [31:0] cv;
  timer_dev #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset), .sel(sel), .addr(addr),
    .we(we), .din(din), .dout(dout), .irq(irq)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; din = d;
    tick();
    sel = 1'b0; we = 1'b0; din = '0;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
    addr = a;
    #1;
    chk(tag, dout, e);
  endtask
  task automatic chk_irq(input string tag, input bit e);
    #1;
    chk(tag, {31'd0, irq}, {31'd0, e});
  endtask
  // k counts edges after the enabling write edge; the first two edges are IDLE->LOAD and the load itself
  function automatic logic [31:0] m_cnt(int p, bit per, int prev, int k);
    int eff, j;
    eff = p == 0 ? 1 : p;
    if (k < 2) return 32'(prev);
    j = per ? (k - 2) % (eff + 2) : k - 2;
    return j <= p ? 32'(p - j) : 32'd0;
  endfunction
  function automatic bit m_irq(int p, bit per, bit im, int k);
    int eff, j;
    eff = p == 0 ? 1 : p;
    if (k < 2 || !im) return 1'b0;
    j = k - 2;
    return per ? (j % (eff + 2)) == eff : j >= eff;
  endfunction
  task automatic run(input int p, input bit per, input bit im, input int prev, input int k0, input int k1);
    for (int k = k0 + 1; k <= k1; k++) begin
      tick();
      chk_reg("count", 2'd2, m_cnt(p, per, prev, k));
      chk_irq("irq", m_irq(p, per, im, k));
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) chk_reg("reset_read", 2'(a), 32'd0);
    chk_irq("reset_irq", 1'b0);
    ps = '{5, 0, int'($urandom_range(1, 9)), int'($urandom_range(0, 12))};
    for (int i = 0; i < 4; i++) begin
      cv = (i == 0 || $urandom_range(0, 1) == 0) ? 32'h9 : 32'hD;
      wr(2'd1, 32'(ps[i]));
      wr(2'd0, cv);
      run(ps[i], 1'b0, 1'b1, 0, 0, ps[i] + 4);
      chk_reg("oneshot_ctrl", 2'd0, cv & ~32'h1);
      tick();
      chk_irq("oneshot_hold", 1'b1);
      wr(2'd0, cv & ~32'h1);
      chk_irq("oneshot_ack", 1'b0);
    end
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    run(2, 1'b0, 1'b1, 0, 0, 5);
    reset = 1'b1;
    chk_irq("async_irq_clear", 1'b0);
    chk_reg("async_ctrl_clear", 2'd0, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    run(3, 1'b1, 1'b1, 0, 0, 23);
    do_reset();
    ps[0] = int'($urandom_range(1, 6));
    wr(2'd1, 32'(ps[0]));
    wr(2'd0, 32'h3);
    run(ps[0], 1'b1, 1'b0, 0, 0, 2 + 3 * (ps[0] + 2));
    do_reset();
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h9);
    run(7, 1'b0, 1'b1, 0, 0, 6);
    reset = 1'b1;
    chk_reg("midcount_reset_cnt", 2'd2, 32'd0);
    chk_irq("midcount_reset_irq", 1'b0);
    chk_reg("midcount_reset_pre", 2'd1, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk_reg("post_reset_cnt", 2'd2, 32'd0);
    wr(2'd1, 32'd6);
    wr(2'd0, 32'hB);
    run(6, 1'b1, 1'b1, 0, 0, 4);
    wr(2'd1, 32'h12);
    chk_reg("preset_midrun_cnt", 2'd2, 32'd3);
    run(6, 1'b1, 1'b1, 0, 5, 9);
    tick();
    chk_reg("preset_reload", 2'd2, 32'h12);
    tick();
    chk_reg("preset_reload_dec", 2'd2, 32'h11);
    do_reset();
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h9);
    run(9, 1'b0, 1'b1, 0, 0, 5);
    wr(2'd0, 32'h0);
    chk_reg("freeze_cnt", 2'd2, 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reg("frozen_cnt", 2'd2, 32'd5);
      chk_irq("frozen_irq", 1'b0);
    end
    wr(2'd0, 32'h9);
    run(9, 1'b0, 1'b1, 5, 0, 12);
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    run(4, 1'b0, 1'b1, 0, 0, 5);
    wr(2'd0, 32'h9);
    chk_irq("race_irq", 1'b1);
    chk_reg("race_ctrl", 2'd0, 32'h9);
    chk_reg("race_cnt", 2'd2, 32'd0);
    tick();
    chk_irq("race_irq_hold", 1'b1);
    tick();
    tick();
    chk_reg("race_reload", 2'd2, 32'd4);
    chk_irq("race_irq_still", 1'b1);
    do_reset();
    wr(2'd1, 32'd7);
    wr(2'd2, 32'hFF);
    wr(2'd3, 32'hAB);
    we = 1'b1; addr = 2'd1; din = 32'h55;
    tick();
    addr = 2'd0; din = 32'h9;
    tick();
    we = 1'b0; din = '0;
    chk_reg("ign_preset", 2'd1, 32'd7);
    chk_reg("ign_ctrl", 2'd0, 32'd0);
    chk_reg("ign_cnt", 2'd2, 32'd0);
    chk_reg("ign_off3", 2'd3, 32'd0);
    wr(2'd0, 32'hFFFF_FFF6);
    chk_reg("ctrl_mask", 2'd0, 32'h6);
    repeat (3) tick();
    chk_reg("ctrl_no_en_cnt", 2'd2, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
